// File: rtl/uart_tx_frame.sv
// ----------------------------------------------------------------------------
// uart_tx_frame : serialises one word per frame, paced by an external bit timer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_tx_frame #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 baud_tick,
  output logic                 timer_act,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int               CNT_W     = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS);
  localparam logic             LAST_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_FLUSH,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 parity_q;
  logic                 parity_d;
  logic                 stop_q;
  logic                 flush_pend_q;
  logic                 timer_act_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 tx_done_q;
  logic                 bit_tick;

  assign cnt_d    = cnt_q + 1'b1;
  assign parity_d = (^tx_data) ^ (PARITY_ODD != 0);
  // A tick landing in the request cycle belongs to the previous timer run.
  assign bit_tick = baud_tick && !timer_act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FLUSH;
      shift_q      <= '0;
      cnt_q        <= '0;
      parity_q     <= 1'b0;
      stop_q       <= 1'b0;
      flush_pend_q <= 1'b1;
      timer_act_q  <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b1;
      tx_done_q    <= 1'b0;
    end else begin
      timer_act_q <= 1'b0;
      tx_done_q   <= 1'b0;
      case (state_q)
        S_FLUSH: begin
          if (flush_pend_q) begin
            flush_pend_q <= 1'b0;
            timer_act_q  <= 1'b1;
          end else if (bit_tick) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_IDLE: begin
          if (tx_start) begin
            shift_q     <= tx_data;
            parity_q    <= parity_d;
            cnt_q       <= '0;
            stop_q      <= 1'b0;
            state_q     <= S_START;
            tx_q        <= 1'b0;
            timer_act_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        default: begin
          if (bit_tick) begin
            timer_act_q <= 1'b1;
            case (state_q)
              S_START: begin
                state_q <= S_DATA;
                tx_q    <= shift_q[0];
              end
              S_DATA: begin
                shift_q <= shift_q >> 1;
                cnt_q   <= cnt_d;
                if (cnt_d == LAST_DATA) begin
                  if (PARITY_EN != 0) begin
                    state_q <= S_PARITY;
                    tx_q    <= parity_q;
                  end else begin
                    state_q <= S_STOP;
                    tx_q    <= 1'b1;
                  end
                end else begin
                  tx_q <= shift_q[1];
                end
              end
              S_PARITY: begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
              S_STOP: begin
                if (stop_q == LAST_STOP) begin
                  state_q     <= S_IDLE;
                  timer_act_q <= 1'b0;
                  tx_done_q   <= 1'b1;
                  busy_q      <= 1'b0;
                end else begin
                  stop_q <= 1'b1;
                end
              end
              default: state_q <= S_FLUSH;
            endcase
          end
        end
      endcase
    end
  end

  assign timer_act = timer_act_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign tx_done   = tx_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_frame : three framings (8N1, 8E2, 8O1) driven by a DIVISOR=8 timer
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_frame;

  localparam int BIT_CYC = 9;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       tx_start  = 1'b0;
  logic [7:0] tx_data   = 8'h00;
  logic       spur_en   = 1'b0;
  logic       spur_idle = 1'b0;

  logic [2:0] baud_tick;
  logic [2:0] timer_act;
  logic [2:0] tx;
  logic [2:0] busy;
  logic [2:0] tx_done;
  logic [2:0] tready = 3'b000;
  logic [2:0] trun   = 3'b000;
  logic [2:0] tcnt [3] = '{3'd0, 3'd0, 3'd0};

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [15:0] bits;
    int          n;
  } frame_t;

  frame_t sb0[$];
  frame_t sb1[$];
  frame_t sb2[$];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .baud_tick(baud_tick[0]), .timer_act(timer_act[0]), .tx(tx[0]),
    .busy(busy[0]), .tx_done(tx_done[0]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .baud_tick(baud_tick[1]), .timer_act(timer_act[1]), .tx(tx[1]),
    .busy(busy[1]), .tx_done(tx_done[1]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
    .baud_tick(baud_tick[2]), .timer_act(timer_act[2]), .tx(tx[2]),
    .busy(busy[2]), .tx_done(tx_done[2]));

  // Timer model: samples isAct on the next edge, hd_ready high DIVISOR cycles
  // after the request edge; a new request restarts the count.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (timer_act[k]) begin
        tcnt[k]   <= 3'd7;
        trun[k]   <= 1'b1;
        tready[k] <= 1'b0;
      end else if (trun[k]) begin
        tready[k] <= (tcnt[k] == 3'd1);
        trun[k]   <= (tcnt[k] != 3'd1);
        tcnt[k]   <= tcnt[k] - 3'd1;
      end else begin
        tready[k] <= 1'b0;
      end
    end
  end

  assign baud_tick = tready | ({3{spur_en}} & timer_act) | {3{spur_idle}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic frame_t exp_frame(input int k, input logic [7:0] d);
    frame_t f;
    int pe = (k != 0) ? 1 : 0;
    int po = (k == 2) ? 1 : 0;
    int ns = (k == 1) ? 2 : 1;
    f.bits    = '0;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[1+i] = d[i];
    f.n = 9;
    if (pe != 0) begin
      f.bits[f.n] = (^d) ^ (po != 0);
      f.n++;
    end
    for (int s = 0; s < ns; s++) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    return f;
  endfunction

  task automatic sb_push(input int k, input frame_t f);
    case (k)
      0:       sb0.push_back(f);
      1:       sb1.push_back(f);
      default: sb2.push_back(f);
    endcase
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  // Monitor: rebuilds each frame from the per-bit timer requests and checks
  // it against the scoreboard entry pushed when the word was accepted.
  logic [15:0] cur_bits [3];
  int          cur_n    [3];
  int          cur_len  [3];
  logic        cur_val  [3];
  logic        inframe  [3] = '{1'b0, 1'b0, 1'b0};
  logic        len_ok   [3];
  int          frames   [3] = '{0, 0, 0};

  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          inframe[k] = 1'b0;
        end else begin
          if (!busy[k] && tx_start) sb_push(k, exp_frame(k, tx_data));
          if (timer_act[k] && (inframe[k] || !tx[k])) begin
            if (inframe[k]) begin
              cur_bits[k][cur_n[k]] = cur_val[k];
              if (cur_len[k] != BIT_CYC) len_ok[k] = 1'b0;
              cur_n[k]++;
            end else begin
              inframe[k]  = 1'b1;
              cur_bits[k] = '0;
              cur_n[k]    = 0;
              len_ok[k]   = 1'b1;
            end
            cur_val[k] = tx[k];
            cur_len[k] = 1;
          end else if (tx_done[k] && inframe[k]) begin
            cur_bits[k][cur_n[k]] = cur_val[k];
            if (cur_len[k] != BIT_CYC) len_ok[k] = 1'b0;
            cur_n[k]++;
            inframe[k] = 1'b0;
            frames[k]++;
            check($sformatf("sb_nonempty%0d", k), (sb_size(k) > 0), 1);
            if (sb_size(k) > 0) begin
              case (k)
                0:       e = sb0.pop_front();
                1:       e = sb1.pop_front();
                default: e = sb2.pop_front();
              endcase
              check($sformatf("frame_bits%0d", k), 32'(cur_bits[k]), 32'(e.bits));
              check($sformatf("frame_nbits%0d", k), cur_n[k], e.n);
              check($sformatf("bit_timing%0d", k), 32'(len_ok[k]), 1);
            end
          end else if (tx_done[k]) begin
            check($sformatf("stray_done%0d", k), 32'(tx_done[k]), 0);
          end else if (inframe[k]) begin
            if (tx[k] !== cur_val[k]) len_ok[k] = 1'b0;
            cur_len[k]++;
          end
        end
      end
      if (!rst_n) begin
        sb0.delete();
        sb1.delete();
        sb2.delete();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_all_idle(input string tag);
    int c = 0;
    while (busy !== 3'b000 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check(tag, (c < 300), 1);
    step();
  endtask

  task automatic wait_busy0(input string tag);
    int c = 0;
    while (busy[0] !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    check(tag, (c < 50), 1);
  endtask

  initial begin
    int   cyc;
    logic clean;

    // Reset state.
    repeat (3) step();
    check("rst_tx", 32'(tx), 32'h7);
    check("rst_busy", 32'(busy), 32'h7);
    check("rst_act", 32'(timer_act), 32'h0);
    check("rst_done", 32'(tx_done), 32'h0);

    // Flush after reset release: one timer request, then busy for 9 cycles.
    rst_n = 1'b1;
    @(negedge clk);
    check("flush_act_pre", 32'(timer_act), 32'h0);
    @(negedge clk);
    check("flush_act", 32'(timer_act), 32'h7);
    cyc   = 1;
    clean = 1'b1;
    while (busy[0] === 1'b1 && cyc < 50) begin
      @(negedge clk);
      if (tx !== 3'b111 || tx_done !== 3'b000) clean = 1'b0;
      if (busy[0] === 1'b1) cyc++;
    end
    check("flush_busy_cycles", cyc, 9);
    check("flush_clean", 32'(clean), 1);
    check("flush_idle_busy", 32'(busy), 32'h0);
    check("flush_idle_tx", 32'(tx), 32'h7);
    step();

    // Plain frames; tx_data is disturbed right after acceptance.
    send(8'hA5);
    tx_data = 8'h00;
    wait_all_idle("idle_a5");
    send(8'h07);
    tx_data = 8'hFF;
    wait_all_idle("idle_07");

    // tx_start held: back-to-back frames on the 8N1 instance.
    tx_data  = 8'h55;
    tx_start = 1'b1;
    wait_busy0("start_55");
    step();
    tx_data = 8'h0F;
    cyc = 0;
    while (tx_done[0] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("done_55", (cyc < 200), 1);
    @(negedge clk);
    check("b2b_start", 32'({tx[0], timer_act[0]}), 32'h1);
    step();
    tx_start = 1'b0;
    repeat (20) step();
    tx_data = 8'hAA;
    wait_all_idle("idle_b2b");

    // Mid-frame tx_start and ticks coincident with timer requests.
    spur_en = 1'b1;
    send(8'h3C);
    repeat (30) step();
    send(8'hFF);
    wait_all_idle("idle_3c");
    spur_en   = 1'b0;
    spur_idle = 1'b1;
    step();
    spur_idle = 1'b0;
    repeat (3) step();
    check("idle_tick_busy", 32'(busy), 32'h0);
    check("idle_tick_act", 32'(timer_act), 32'h0);
    check("idle_tick_tx", 32'(tx), 32'h7);

    // Reset during data bit 3 (a zero bit of 8'h96).
    send(8'h96);
    wait_busy0("start_96");
    repeat (40) step();
    check("pre_reset_bit3", 32'(tx[0]), 0);
    rst_n = 1'b0;
    #1;
    check("abort_tx", 32'(tx), 32'h7);
    check("abort_busy", 32'(busy), 32'h7);
    repeat (2) step();
    rst_n = 1'b1;
    wait_all_idle("idle_after_reset");
    send(8'hC3);
    wait_all_idle("idle_c3");

    repeat (5) step();
    check("sb_empty0", sb_size(0), 0);
    check("sb_empty1", sb_size(1), 0);
    check("sb_empty2", sb_size(2), 0);
    check("frames0", frames[0], 6);
    check("frames1", frames[1], 5);
    check("frames2", frames[2], 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
